// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Brief    : Shared types and helpers for the TDC sample controller.
// Revision : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } tdc_ctrl_state_t;

    // Width needed to hold a popcount of 0..n inclusive.
    function automatic int hw_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_stats_acc.sv
`default_nettype none
// ============================================================================
// Module   : tdc_stats_acc
// Brief    : Running sum/min/max/count of TDC hamming-weight samples.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_stats_acc #(
    parameter int HW_W  = 7,
    parameter int CNT_W = 8,
    parameter int SUM_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [HW_W-1:0]  hw_in,
    output logic [SUM_W-1:0] sum,
    output logic [HW_W-1:0]  min_hw,
    output logic [HW_W-1:0]  max_hw,
    output logic [CNT_W-1:0] count
);

    logic [SUM_W-1:0] sum_q,   sum_d;
    logic [HW_W-1:0]  min_q,   min_d;
    logic [HW_W-1:0]  max_q,   max_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over accumulate; min starts at all-ones so the first sample always replaces it.
    always_comb begin
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        if (clear) begin
            sum_d   = '0;
            min_d   = '1;
            max_d   = '0;
            count_d = '0;
        end else if (en) begin
            sum_d   = sum_q + SUM_W'(hw_in);
            count_d = count_q + CNT_W'(1);
            if (hw_in < min_q) min_d = hw_in;
            if (hw_in > max_q) max_d = hw_in;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            min_q   <= '1;
            max_q   <= '0;
            count_q <= '0;
        end else begin
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

    assign sum    = sum_q;
    assign min_hw = min_q;
    assign max_hw = max_q;
    assign count  = count_q;

endmodule
`default_nettype wire

// File: rtl/tdc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tdc_sample_ctrl
// Brief    : Launches TDC pulses, reads hw after fixed latency, accumulates
//            sum/min/max over a run and returns them via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_sample_ctrl
    import tdc_pkg::*;
#(
    parameter  int N     = 64,
    parameter  int LAT   = 3,
    parameter  int CNT_W = 8,
    localparam int HW_W  = hw_width(N),
    localparam int SUM_W = HW_W + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    output logic             busy,
    output logic             pg_en,
    output logic             pg_tog,
    input  logic [HW_W-1:0]  hw_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W-1:0] res_sum,
    output logic [HW_W-1:0]  res_min,
    output logic [HW_W-1:0]  res_max,
    output logic [CNT_W-1:0] res_count
);

    localparam int                   c_wait_w    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_wait_w-1:0]  c_wait_init = c_wait_w'(LAT - 1);
    localparam logic [HW_W-1:0]      c_hw_max    = HW_W'(N);

    tdc_ctrl_state_t     state_q,     state_d;
    logic [c_wait_w-1:0] wait_q,      wait_d;
    logic [CNT_W-1:0]    target_q,    target_d;
    logic                pg_tog_q,    pg_tog_d;
    logic                pg_en_q,     pg_en_d;
    logic                res_valid_q, res_valid_d;
    logic                acc_clear;
    logic                acc_en;

    // Next-state, wait counter and accumulator control; pg_en/res_valid are
    // decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        target_d  = target_q;
        pg_tog_d  = pg_tog_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (n_samples != '0)) begin
                    target_d  = n_samples;
                    acc_clear = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                pg_tog_d = ~pg_tog_q;
                wait_d   = c_wait_init;
                state_d  = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) state_d = SAMPLE;
                else              wait_d  = wait_q - c_wait_w'(1);
            end
            SAMPLE: begin
                acc_en = 1'b1;
                if ((res_count + CNT_W'(1)) == target_q) state_d = DONE;
                else                                     state_d = LAUNCH;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pg_en_d     = (state_d == LAUNCH) || (state_d == WAIT) || (state_d == SAMPLE);
        res_valid_d = (state_d == DONE);
    end

    // Control registers; pg_tog level deliberately survives run completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            target_q    <= '0;
            pg_tog_q    <= 1'b0;
            pg_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            target_q    <= target_d;
            pg_tog_q    <= pg_tog_d;
            pg_en_q     <= pg_en_d;
            res_valid_q <= res_valid_d;
        end
    end

    tdc_stats_acc #(
        .HW_W  (HW_W),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_stats (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .en     (acc_en),
        .hw_in  (hw_in),
        .sum    (res_sum),
        .min_hw (res_min),
        .max_hw (res_max),
        .count  (res_count)
    );

    assign busy      = (state_q != IDLE);
    assign pg_en     = pg_en_q;
    assign pg_tog    = pg_tog_q;
    assign res_valid = res_valid_q;

`ifndef SYNTHESIS
    a_hw_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SAMPLE) |-> (hw_in <= c_hw_max))
        else $error("hw_in above N in SAMPLE cycle");
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_sample_ctrl
// Brief    : Self-checking bench for tdc_sample_ctrl (N=64, LAT=3, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_sample_ctrl;

    localparam int N     = 64;
    localparam int LAT   = 3;
    localparam int CNT_W = 8;
    localparam int HW_W  = 7;
    localparam int SUM_W = HW_W + CNT_W;
    localparam int P     = LAT + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             busy, pg_en, pg_tog;
    logic [HW_W-1:0]  hw_in;
    logic             res_valid, res_ready;
    logic [SUM_W-1:0] res_sum;
    logic [HW_W-1:0]  res_min, res_max;
    logic [CNT_W-1:0] res_count;

    int n_checks = 0;
    int n_pass   = 0;
    int pattern[$];

    typedef struct {
        int n;
        int a;
        int b;
        int filler;
        int e_sum;
        int e_min;
        int e_max;
    } vec_t;

    always #5 clk = ~clk;

    tdc_sample_ctrl #(.N(N), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_samples (n_samples),
        .busy      (busy),
        .pg_en     (pg_en),
        .pg_tog    (pg_tog),
        .hw_in     (hw_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_min   (res_min),
        .res_max   (res_max),
        .res_count (res_count)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " busy"},      busy,      0);
        chk({tag, " pg_en"},     pg_en,     0);
        chk({tag, " pg_tog"},    pg_tog,    0);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " res_sum"},   res_sum,   0);
        chk({tag, " res_min"},   res_min,   127);
        chk({tag, " res_max"},   res_max,   0);
        chk({tag, " res_count"}, res_count, 0);
    endtask

    function automatic int fill_val(input int filler);
        return (filler < 0) ? int'($urandom_range(0, 127)) : filler;
    endfunction

    // One full run: samples are drawn from 'pattern' (cycled) or random when
    // the pattern is empty; the value is presented only in the cycle the
    // controller should sample (every P-th cycle after the accepting edge).
    // Expected stats come from the table (e_sum >= 0) or from the queue of
    // samples actually presented.
    task automatic run(input int n, input int filler, input int e_sum, input int e_min,
                       input int e_max, input string tag, input bit ack);
        int   q[$];
        int   toggles, v, m_sum, m_min, m_max;
        bit   early_valid, pg_en_low, busy_low;
        logic prev_tog;
        toggles = 0; early_valid = 0; pg_en_low = 0; busy_low = 0;
        prev_tog = pg_tog;
        @(negedge clk);
        start = 1'b1; n_samples = CNT_W'(n); hw_in = HW_W'(fill_val(filler));
        for (int j = 1; j <= n * P; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (res_valid) early_valid = 1;
            if (!pg_en)    pg_en_low   = 1;
            if (!busy)     busy_low    = 1;
            if (pg_tog !== prev_tog) toggles++;
            prev_tog = pg_tog;
            if (j % P == 0) begin
                v = (pattern.size() == 0) ? int'($urandom_range(0, N))
                                          : pattern[q.size() % pattern.size()];
                q.push_back(v);
                hw_in = HW_W'(v);
            end else begin
                hw_in = HW_W'(fill_val(filler));
            end
        end
        @(negedge clk);
        hw_in = HW_W'(fill_val(filler));
        if (pg_tog !== prev_tog) toggles++;
        m_sum = 0; m_min = 127; m_max = 0;
        foreach (q[k]) begin
            m_sum += q[k];
            if (q[k] < m_min) m_min = q[k];
            if (q[k] > m_max) m_max = q[k];
        end
        if (e_sum < 0) begin e_sum = m_sum; e_min = m_min; e_max = m_max; end
        chk({tag, " early_valid"},  early_valid, 0);
        chk({tag, " pg_en_in_run"}, pg_en_low,   0);
        chk({tag, " busy_in_run"},  busy_low,    0);
        chk({tag, " valid_at_end"}, res_valid,   1);
        chk({tag, " pg_en_done"},   pg_en,       0);
        chk({tag, " tog_edges"},    toggles,     n);
        chk({tag, " sum"},          res_sum,     e_sum);
        chk({tag, " min"},          res_min,     e_min);
        chk({tag, " max"},          res_max,     e_max);
        chk({tag, " count"},        res_count,   n);
        if (ack) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk({tag, " busy_after_ack"},  busy,      0);
            chk({tag, " valid_after_ack"}, res_valid, 0);
            chk({tag, " sum_kept"},        res_sum,   e_sum);
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [SUM_W-1:0] h_sum;
        logic [HW_W-1:0]  h_min, h_max;
        logic             h_tog;
        bit               unstable, bad;

        vecs[0] = '{n: 1,   a: 17, b: 17, filler: 0,  e_sum: 17,    e_min: 17, e_max: 17};
        vecs[1] = '{n: 255, a: 64, b: 64, filler: 0,  e_sum: 16320, e_min: 64, e_max: 64};
        vecs[2] = '{n: 255, a: 0,  b: 0,  filler: 64, e_sum: 0,     e_min: 0,  e_max: 0};
        vecs[3] = '{n: 3,   a: 7,  b: 7,  filler: 64, e_sum: 21,    e_min: 7,  e_max: 7};
        vecs[4] = '{n: 6,   a: 1,  b: 50, filler: 33, e_sum: 153,   e_min: 1,  e_max: 50};
        vecs[5] = '{n: 2,   a: 64, b: 0,  filler: 5,  e_sum: 64,    e_min: 0,  e_max: 64};

        rst_n = 1'b0; start = 1'b0; n_samples = '0; hw_in = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run: 10,20,5,33 with large filler off-window.
        pattern = {10, 20, 5, 33};
        run(4, 64, 68, 5, 33, "basic", 1'b1);

        // Zero samples: ignored entirely.
        h_tog = pg_tog; bad = 0;
        @(negedge clk); start = 1'b1; n_samples = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); start = 1'b0;
            if (busy || res_valid || (pg_tog !== h_tog)) bad = 1;
        end
        chk("zero_samples_ignored", bad, 0);

        // Table vectors.
        foreach (vecs[i]) begin
            pattern = {vecs[i].a, vecs[i].b};
            run(vecs[i].n, vecs[i].filler, vecs[i].e_sum, vecs[i].e_min, vecs[i].e_max,
                $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: hold result 10 cycles with a stray start in the window.
        pattern = {12, 40, 3};
        run(3, 0, 55, 3, 40, "bp", 1'b0);
        h_sum = res_sum; h_min = res_min; h_max = res_max; h_tog = pg_tog; unstable = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4); n_samples = 8'd5;
            @(negedge clk);
            if (!busy || !res_valid || res_sum !== h_sum || res_min !== h_min ||
                res_max !== h_max || res_count !== 8'd3 || pg_tog !== h_tog || pg_en)
                unstable = 1;
        end
        start = 1'b0;
        chk("bp_stable", unstable, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_idle_after_ack", busy, 0);
        chk("bp_valid_drop", res_valid, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || pg_tog !== h_tog) bad = 1;
        end
        chk("bp_start_not_queued", bad, 0);

        // Mid-run reset during WAIT of sample 2.
        pattern = {9};
        @(negedge clk); start = 1'b1; n_samples = 8'd3; hw_in = 7'd9;
        repeat (8) begin @(negedge clk); start = 1'b0; end
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pattern = {3, 9};
        run(2, 0, 12, 3, 9, "post_rst", 1'b1);

        // Randomised runs checked against the queue model, random filler.
        pattern = {};
        for (int r = 0; r < 4; r++)
            run(int'($urandom_range(1, 20)), -1, -1, 0, 0, $sformatf("rand%0d", r), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
